// File: rtl/shift_pkg.sv
// Shared encodings and the stage-1 decode for the pipelined operand-2 shifter.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_LSL = 2'b00,
        ST_LSR = 2'b01,
        ST_ASR = 2'b10,
        ST_ROR = 2'b11
    } shift_type_e;

    typedef enum logic [2:0] {
        OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX, OP_PASS, OP_ZERO, OP_SIGN
    } eff_op_e;

    // CS_CORE takes the barrel's own carry; the others cover the boundary cases.
    typedef enum logic [1:0] {
        CS_CORE, CS_ZERO, CS_LSB, CS_MSB
    } csel_e;

    typedef struct packed {
        eff_op_e     op;
        logic [31:0] amt;
        csel_e       csel;
    } dec_t;

    function automatic dec_t shift_decode(
        input logic        imm_or_reg,
        input logic        amt_from_reg,
        input logic [1:0]  st,
        input logic [31:0] amt_imm,
        input logic [31:0] amt_reg,
        input logic [31:0] rot_code,
        input int unsigned data_w
    );
        dec_t        d;
        logic [31:0] mask;
        mask   = data_w - 1;
        d.op   = OP_PASS;
        d.amt  = '0;
        d.csel = CS_CORE;
        if (imm_or_reg) begin
            d.amt = (rot_code << 1) & mask;
            if (rot_code == 0)  d.op = OP_PASS;
            else if (d.amt == 0) d.csel = CS_MSB;
            else                 d.op = OP_ROR;
        end else if (!amt_from_reg) begin
            d.amt = amt_imm;
            case (st)
                ST_LSL:  d.op = (amt_imm == 0) ? OP_PASS : OP_LSL;
                ST_LSR:  begin
                    d.op = (amt_imm == 0) ? OP_ZERO : OP_LSR;
                    if (amt_imm == 0) d.csel = CS_MSB;
                end
                ST_ASR:  d.op = (amt_imm == 0) ? OP_SIGN : OP_ASR;
                default: d.op = (amt_imm == 0) ? OP_RRX : OP_ROR;
            endcase
        end else if (amt_reg != 0) begin
            d.amt = amt_reg & mask;
            case (st)
                ST_LSL, ST_LSR: begin
                    if (amt_reg < data_w) begin
                        d.op = (st == ST_LSL) ? OP_LSL : OP_LSR;
                    end else begin
                        d.op = OP_ZERO;
                        if (amt_reg > data_w)  d.csel = CS_ZERO;
                        else if (st == ST_LSL) d.csel = CS_LSB;
                        else                   d.csel = CS_MSB;
                    end
                end
                ST_ASR:  d.op = (amt_reg < data_w) ? OP_ASR : OP_SIGN;
                default: begin
                    if (d.amt == 0) d.csel = CS_MSB;
                    else            d.op = OP_ROR;
                end
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational log2(DATA_W)-stage barrel shifter over the normalised effective op.
module shift_core
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  eff_op_e                     op_i,
    input  logic [$clog2(DATA_W)-1:0]   amt_i,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        carry_i,
    output logic [DATA_W-1:0]           data_o,
    output logic                        carry_o
);
    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] v;
    logic [SH_W-1:0]   lsl_idx;
    logic [SH_W-1:0]   rsh_idx;

    always_comb begin
        v = data_i;
        for (int unsigned k = 0; k < SH_W; k++) begin
            if (amt_i[k]) begin
                case (op_i)
                    OP_LSL:  v = v << (1 << k);
                    OP_LSR:  v = v >> (1 << k);
                    OP_ASR:  v = DATA_W'($signed(v) >>> (1 << k));
                    OP_ROR:  v = (v >> (1 << k)) | (v << (DATA_W - (1 << k)));
                    default: v = v;
                endcase
            end
        end
    end

    // Last bit shifted out: in[N-a] for LSL, in[a-1] for right shifts.
    assign lsl_idx = '0 - amt_i;
    assign rsh_idx = amt_i - SH_W'(1);

    always_comb begin
        data_o  = v;
        carry_o = carry_i;
        case (op_i)
            OP_LSL:         carry_o = data_i[lsl_idx];
            OP_LSR, OP_ASR: carry_o = data_i[rsh_idx];
            OP_ROR:         carry_o = v[DATA_W-1];
            OP_RRX: begin
                data_o  = {carry_i, data_i[DATA_W-1:1]};
                carry_o = data_i[0];
            end
            OP_ZERO: begin
                data_o  = '0;
                carry_o = 1'b0;
            end
            OP_SIGN: begin
                data_o  = {DATA_W{data_i[DATA_W-1]}};
                carry_o = data_i[DATA_W-1];
            end
            default: begin
                data_o  = data_i;
                carry_o = carry_i;
            end
        endcase
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined ARM operand-2 shifter: decode register, then barrel into output register.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AMT_W  = 8,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned ROT_W  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        imm_or_reg,
    input  logic                        amt_from_reg,
    input  logic [1:0]                  shift_type,
    input  logic [$clog2(DATA_W)-1:0]   shift_amt_imm,
    input  logic [AMT_W-1:0]            shift_amt_reg,
    input  logic [IMM_W-1:0]            in_data_imm,
    input  logic [ROT_W-1:0]            rotation_code,
    input  logic                        carry_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        carry_out
);
    localparam int unsigned SH_W = $clog2(DATA_W);

    dec_t              dec;
    logic              dec_amt_unused;
    logic              s1_ready, s2_ready, accept, advance;
    logic              s1_valid_q, s1_valid_d;
    eff_op_e           s1_op_q, s1_op_d;
    logic [SH_W-1:0]   s1_amt_q, s1_amt_d;
    csel_e             s1_csel_q, s1_csel_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              s1_cin_q, s1_cin_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              carry_q, carry_d;
    logic [DATA_W-1:0] core_data;
    logic              core_carry, s2_carry;

    assign s2_ready = !out_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;
    assign accept   = in_valid && s1_ready && !flush;
    assign advance  = s1_valid_q && s2_ready && !flush;

    always_comb begin
        dec = shift_decode(imm_or_reg, amt_from_reg, shift_type, 32'(shift_amt_imm),
                           32'(shift_amt_reg), 32'(rotation_code), DATA_W);
    end
    assign dec_amt_unused = ^dec.amt[31:SH_W];

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_amt_d   = s1_amt_q;
        s1_csel_d  = s1_csel_q;
        s1_data_d  = s1_data_q;
        s1_cin_d   = s1_cin_q;
        if (flush)         s1_valid_d = 1'b0;
        else if (s1_ready) s1_valid_d = in_valid;
        if (accept) begin
            s1_op_d   = dec.op;
            s1_amt_d  = dec.amt[SH_W-1:0];
            s1_csel_d = dec.csel;
            s1_data_d = imm_or_reg ? DATA_W'(in_data_imm) : in_data;
            s1_cin_d  = carry_in;
        end
    end

    shift_core #(.DATA_W(DATA_W)) u_core (
        .op_i    (s1_op_q),
        .amt_i   (s1_amt_q),
        .data_i  (s1_data_q),
        .carry_i (s1_cin_q),
        .data_o  (core_data),
        .carry_o (core_carry)
    );

    always_comb begin
        case (s1_csel_q)
            CS_ZERO: s2_carry = 1'b0;
            CS_LSB:  s2_carry = s1_data_q[0];
            CS_MSB:  s2_carry = s1_data_q[DATA_W-1];
            default: s2_carry = core_carry;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        carry_d     = carry_q;
        if (flush)         out_valid_d = 1'b0;
        else if (s2_ready) out_valid_d = s1_valid_q;
        if (advance) begin
            out_data_d = core_data;
            carry_d    = s2_carry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            carry_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            carry_q     <= carry_d;
        end
    end

    // Stage-1 payload needs no reset: it is only observed behind s1_valid_q.
    always_ff @(posedge clk) begin
        s1_op_q   <= s1_op_d;
        s1_amt_q  <= s1_amt_d;
        s1_csel_q <= s1_csel_d;
        s1_data_q <= s1_data_d;
        s1_cin_q  <= s1_cin_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe: directed vectors, decoupled output monitor.
module tb_shift_unit_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        imm_or_reg = 1'b0;
    logic        amt_from_reg = 1'b0;
    logic [1:0]  shift_type = '0;
    logic [4:0]  shift_amt_imm = '0;
    logic [7:0]  shift_amt_reg = '0;
    logic [7:0]  in_data_imm = '0;
    logic [3:0]  rotation_code = '0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        carry_out;

    typedef struct {
        logic [31:0] d;
        logic        c;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned nvec = 0;
    int unsigned nerr = 0;
    int unsigned cyc = 0;
    bit          lat_chk = 1'b0;

    shift_unit_pipe #(
        .DATA_W (32),
        .AMT_W  (8),
        .IMM_W  (8),
        .ROT_W  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .imm_or_reg    (imm_or_reg),
        .amt_from_reg  (amt_from_reg),
        .shift_type    (shift_type),
        .shift_amt_imm (shift_amt_imm),
        .shift_amt_reg (shift_amt_reg),
        .in_data_imm   (in_data_imm),
        .rotation_code (rotation_code),
        .carry_in      (carry_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .carry_out     (carry_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic ior, input logic afr, input logic [1:0] st,
                        input logic [4:0] ai, input logic [7:0] ar, input logic [7:0] im,
                        input logic [3:0] rc, input logic cin, input logic [31:0] d,
                        input logic [31:0] ed, input logic ec);
        bit done = 1'b0;
        imm_or_reg    = ior;
        amt_from_reg  = afr;
        shift_type    = st;
        shift_amt_imm = ai;
        shift_amt_reg = ar;
        in_data_imm   = im;
        rotation_code = rc;
        carry_in      = cin;
        in_data       = d;
        in_valid      = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{ed, ec, cyc});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: compares each transfer against the scoreboard head and checks hold stability.
    bit          hold_v = 1'b0;
    logic [31:0] hold_d;
    logic        hold_c;
    always @(negedge clk) begin
        exp_t e;
        if (hold_v && out_valid) begin
            chk("hold_data", out_data, hold_d);
            chk("hold_carry", 32'(carry_out), 32'(hold_c));
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_c = carry_out;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", out_data, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("data", out_data, e.d);
                chk("carry", 32'(carry_out), 32'(e.c));
                if (lat_chk) chk("latency", cyc - e.cyc, 32'd2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back vectors, no backpressure: fixed 2-cycle latency.
        lat_chk = 1'b1;
        //    ior afr st    ai     ar      im      rc    cin data          exp_data      exp_c
        send(0, 1, 2'b00, 5'd0,  8'd32,  8'h00, 4'd0, 0, 32'h8000_0001, 32'h0000_0000, 1);
        send(0, 1, 2'b00, 5'd0,  8'd33,  8'h00, 4'd0, 0, 32'h8000_0001, 32'h0000_0000, 0);
        send(0, 0, 2'b01, 5'd0,  8'd0,   8'h00, 4'd0, 0, 32'h8000_0000, 32'h0000_0000, 1);
        send(0, 1, 2'b10, 5'd0,  8'd200, 8'h00, 4'd0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        send(0, 0, 2'b11, 5'd0,  8'd0,   8'h00, 4'd0, 1, 32'h0000_0003, 32'h8000_0001, 1);
        send(0, 1, 2'b11, 5'd0,  8'd64,  8'h00, 4'd0, 0, 32'h8000_0000, 32'h8000_0000, 1);
        send(1, 0, 2'b00, 5'd0,  8'd0,   8'hFF, 4'd4, 0, 32'h1234_5678, 32'hFF00_0000, 1);
        send(1, 0, 2'b00, 5'd0,  8'd0,   8'hFF, 4'd0, 0, 32'h1234_5678, 32'h0000_00FF, 0);
        send(0, 0, 2'b00, 5'd4,  8'd0,   8'h00, 4'd0, 0, 32'hF000_000F, 32'h0000_00F0, 1);
        send(0, 0, 2'b01, 5'd4,  8'd0,   8'h00, 4'd0, 0, 32'hF000_000F, 32'h0F00_0000, 1);
        send(0, 0, 2'b10, 5'd4,  8'd0,   8'h00, 4'd0, 0, 32'h8000_0010, 32'hF800_0001, 0);
        send(0, 1, 2'b11, 5'd0,  8'd8,   8'h00, 4'd0, 0, 32'h1234_5678, 32'h7812_3456, 0);
        send(0, 0, 2'b00, 5'd0,  8'd0,   8'h00, 4'd0, 1, 32'h0000_1234, 32'h0000_1234, 1);
        send(0, 1, 2'b01, 5'd0,  8'd32,  8'h00, 4'd0, 0, 32'h8000_0000, 32'h0000_0000, 1);
        send(0, 1, 2'b01, 5'd0,  8'd33,  8'h00, 4'd0, 1, 32'h8000_0000, 32'h0000_0000, 0);
        send(0, 1, 2'b01, 5'd0,  8'd0,   8'h00, 4'd0, 0, 32'h0000_ABCD, 32'h0000_ABCD, 0);
        send(0, 0, 2'b10, 5'd0,  8'd0,   8'h00, 4'd0, 1, 32'h7FFF_FFFF, 32'h0000_0000, 0);
        send(0, 1, 2'b00, 5'd0,  8'd1,   8'h00, 4'd0, 0, 32'h8000_0001, 32'h0000_0002, 1);
        send(0, 1, 2'b00, 5'd0,  8'd31,  8'h00, 4'd0, 1, 32'h0000_0001, 32'h8000_0000, 0);
        send(0, 1, 2'b11, 5'd0,  8'd36,  8'h00, 4'd0, 0, 32'h0000_0008, 32'h8000_0000, 1);
        send(0, 0, 2'b11, 5'd1,  8'd0,   8'h00, 4'd0, 0, 32'h0000_0001, 32'h8000_0000, 1);
        send(1, 1, 2'b10, 5'd7,  8'd99,  8'h3F, 4'd1, 0, 32'hFFFF_FFFF, 32'hC000_000F, 1);
        send(0, 0, 2'b10, 5'd31, 8'd0,   8'h00, 4'd0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        drain();
        lat_chk = 1'b0;

        // Backpressure: two ops fill the pipe, in_ready drops, outputs held.
        out_ready = 1'b0;
        send(0, 0, 2'b00, 5'd4, 8'd0,  8'h00, 4'd0, 0, 32'hF000_000F, 32'h0000_00F0, 1);
        send(0, 1, 2'b11, 5'd0, 8'd8,  8'h00, 4'd0, 0, 32'h1234_5678, 32'h7812_3456, 0);
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(0, 1, 2'b10, 5'd0, 8'd200, 8'h00, 4'd0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        send(1, 0, 2'b00, 5'd0, 8'd0,   8'hFF, 4'd4, 0, 32'h0000_0000, 32'hFF00_0000, 1);
        drain();

        // Flush with two ops in flight and a third presented on the flush cycle.
        send(0, 0, 2'b01, 5'd4, 8'd0, 8'h00, 4'd0, 0, 32'hF000_000F, 32'h0F00_0000, 1);
        send(0, 1, 2'b10, 5'd0, 8'd200, 8'h00, 4'd0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        in_data      = 32'h0000_0003;
        imm_or_reg   = 1'b0;
        amt_from_reg = 1'b0;
        shift_type   = 2'b11;
        shift_amt_imm = 5'd0;
        carry_in     = 1'b1;
        in_valid     = 1'b1;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("flush_quiet", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Reset with two ops in flight, output held non-zero.
        out_ready = 1'b0;
        send(0, 1, 2'b10, 5'd0, 8'd200, 8'h00, 4'd0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        send(0, 0, 2'b00, 5'd4, 8'd0,   8'h00, 4'd0, 0, 32'hF000_000F, 32'h0000_00F0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", out_data, 32'd0);
        chk("mid_rst_carry", 32'(carry_out), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(0, 0, 2'b11, 5'd0, 8'd0, 8'h00, 4'd0, 1, 32'h0000_0003, 32'h8000_0001, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
